// File: rtl/mem_io_pkg.sv
// Shared types and constants for the memory/I-O responder on the accumulator CPU load/store bus.
package mem_io_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam logic [WORD_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM; contents are deliberately not reset.
module data_ram
  import mem_io_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: accepts one word request, waits WAIT_CYCLES, then acks with read data.
// Owns the data RAM and the memory-mapped FPGA I/O word.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [WORD_W-1:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ack,
  output logic [WORD_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  input  logic [WORD_W-1:0] FPGAIn,
  output logic [WORD_W-1:0] FPGAOut
);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_d;
  mem_req_t          live, cap, eff;
  logic              accept, enter_resp;
  logic              is_io, is_ram, out_of_range;
  logic              ram_en, ram_sel;
  logic [WORD_W-1:0] ram_dout, io_word;

  // With zero wait states the RESP-entry edge is the acceptance edge, so decode must see the live request.
  always_comb begin
    live         = {we, addr, wdata};
    eff          = (state == IDLE) ? live : cap;
    is_io        = (eff.addr == IO_ADDR);
    is_ram       = !is_io && ((eff.addr >> ADDR_W) == '0);
    out_of_range = !is_io && !is_ram;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            cnt_d      = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) next_state = RESP;
        else           cnt_d      = cnt - CNT_W'(1);
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    enter_resp = (next_state == RESP);
  end

  // Gated by reset so an aborted access can never touch the un-reset RAM.
  assign ram_en = enter_resp && is_ram && !reset;

  data_ram #(.ADDR_W(ADDR_W)) u_data_ram (
    .CLK  (CLK),
    .en   (ram_en),
    .we   (eff.we),
    .addr (eff.addr[ADDR_W-1:0]),
    .din  (eff.wdata),
    .dout (ram_dout)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      cap     <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      ram_sel <= 1'b0;
      io_word <= '0;
      FPGAOut <= '0;
    end else begin
      cnt  <= cnt_d;
      ack  <= enter_resp;
      err  <= enter_resp && out_of_range;
      busy <= (next_state != IDLE);
      if (accept) cap <= live;
      if (enter_resp) begin
        ram_sel <= is_ram && !eff.we;
        io_word <= (is_io && !eff.we) ? FPGAIn : '0;
        if (is_io && eff.we) FPGAOut <= eff.wdata;
      end
    end
  end

  // Read data is driven only during the ack cycle; stores and out-of-range loads return zero.
  always_comb begin
    rdata = '0;
    if (ack) rdata = ram_sel ? ram_dout : io_word;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: one WAIT_CYCLES=1 instance and one WAIT_CYCLES=0 instance.
module tb_mem_io_responder;

  logic        CLK;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] FPGAIn;

  logic        ack1, err1, busy1;
  logic [15:0] rdata1, fo1;
  logic        ack0, err0, busy0;
  logic [15:0] rdata0, fo0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] init_a [6] = '{16'h0000, 16'h0005, 16'h0020, 16'h0021, 16'h0022, 16'h002F};
  logic [15:0] init_d [6] = '{16'h0000, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'hDEAD};
  logic [15:0] t5_exp [3] = '{16'h1111, 16'h2222, 16'h3333};

  mem_io_responder #(.ADDR_W(10), .WAIT_CYCLES(1), .IO_ADDR(16'hFFFF)) dut1 (
    .CLK(CLK), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1),
    .FPGAIn(FPGAIn), .FPGAOut(fo1)
  );

  mem_io_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .CLK(CLK), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0),
    .FPGAIn(FPGAIn), .FPGAOut(fo0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request; sel=0 observes the zero-wait instance. lat counts rising edges from acceptance to ack.
  task automatic access(input bit sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output logic er, output logic [15:0] fo);
    lat = 0; rd = '0; er = 1'b0; fo = '0;
    @(negedge CLK);
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int k = 1; k <= 20; k++) begin
      logic        o_ack, o_busy, o_err;
      logic [15:0] o_rd, o_fo;
      @(posedge CLK);
      @(negedge CLK);
      o_ack  = sel ? ack1   : ack0;
      o_busy = sel ? busy1  : busy0;
      o_err  = sel ? err1   : err0;
      o_rd   = sel ? rdata1 : rdata0;
      o_fo   = sel ? fo1    : fo0;
      if (k == 1) begin
        req = 1'b0; we = ~w; addr = 16'h0333; wdata = 16'h7777;
      end
      if (o_ack) begin
        lat = k; rd = o_rd; er = o_err; fo = o_fo;
        check("busy_ack", o_busy, 1);
        break;
      end else begin
        check("busy_wait", o_busy, 1);
        check("rdata_idle", o_rd, 0);
      end
    end
  endtask

  initial begin
    int          lat;
    logic [15:0] rd, fo;
    logic        er;

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; FPGAIn = '0;
    repeat (2) @(negedge CLK);
    check("rst_ack", ack1, 0);
    check("rst_err", err1, 0);
    check("rst_busy", busy1, 0);
    check("rst_rdata", rdata1, 0);
    check("rst_fpgaout", fo1, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      access(1, 1, init_a[i], init_d[i], lat, rd, er, fo);
      check("init_err", er, 0);
    end

    // RAM store then load, two-edge latency
    access(1, 1, 16'h0010, 16'h0A00, lat, rd, er, fo);
    check("t1_st_lat", lat, 2);
    check("t1_st_err", er, 0);
    access(1, 0, 16'h0010, 16'h0000, lat, rd, er, fo);
    check("t1_ld_lat", lat, 2);
    check("t1_ld_rdata", rd, 16'h0A00);
    check("t1_ld_err", er, 0);

    // I/O store and load
    access(1, 1, 16'hFFFF, 16'h1234, lat, rd, er, fo);
    check("t2_st_fpgaout_at_ack", fo, 16'h1234);
    check("t2_st_rdata", rd, 0);
    FPGAIn = 16'h00A5;
    access(1, 0, 16'hFFFF, 16'h0000, lat, rd, er, fo);
    check("t2_ld_rdata", rd, 16'h00A5);
    check("t2_ld_err", er, 0);
    check("t2_fpgaout_hold", fo1, 16'h1234);

    // Out-of-range accesses
    access(1, 0, 16'h0400, 16'h0000, lat, rd, er, fo);
    check("t3_ld_lat", lat, 2);
    check("t3_ld_err", er, 1);
    check("t3_ld_rdata", rd, 0);
    access(1, 1, 16'h0400, 16'hBEEF, lat, rd, er, fo);
    check("t3_st_err", er, 1);
    check("t3_st_fpgaout", fo, 16'h1234);
    access(1, 0, 16'h0000, 16'h0000, lat, rd, er, fo);
    check("t3_ram0_rdata", rd, 16'h0000);
    check("t3_ram0_err", er, 0);
    @(negedge CLK);
    check("t3_err_pulse", err1, 0);

    // Reset during WAIT aborts a pending store
    @(negedge CLK);
    req = 1'b1; we = 1'b1; addr = 16'h0005; wdata = 16'h5555;
    @(posedge CLK);
    @(negedge CLK);
    req = 1'b0;
    check("t4_busy_wait", busy1, 1);
    reset = 1'b1;
    #1;
    check("t4_busy_rst", busy1, 0);
    check("t4_fpgaout_rst", fo1, 0);
    @(negedge CLK);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("t4_no_ack", ack1, 0);
      check("t4_busy_idle", busy1, 0);
    end
    access(1, 0, 16'h0005, 16'h0000, lat, rd, er, fo);
    check("t4_ld_rdata", rd, 16'h0000);
    check("t4_ld_lat", lat, 2);

    // req held high across three loads; addr scrambled during WAIT
    @(negedge CLK);
    req = 1'b1; we = 1'b0; addr = 16'h0020;
    for (int k = 1; k <= 9; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("t5_ack_e%0d", k), ack1, 32'((k % 3) == 2));
      if ((k % 3) == 2) check($sformatf("t5_rdata_e%0d", k), rdata1, t5_exp[k / 3]);
      if ((k % 3) == 1)      addr = 16'h002F;
      else if ((k % 3) == 2) addr = 16'h0020 + 16'(k / 3 + 1);
      if (k == 8) req = 1'b0;
    end

    // Zero wait states
    access(0, 1, 16'h03FF, 16'hFFFF, lat, rd, er, fo);
    check("t6_st_lat", lat, 1);
    check("t6_st_err", er, 0);
    access(0, 0, 16'h03FF, 16'h0000, lat, rd, er, fo);
    check("t6_ld_lat", lat, 1);
    check("t6_ld_rdata", rd, 16'hFFFF);
    check("t6_ld_err", er, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
